// File: rtl/sgnext_rr_arb.sv
// Round-robin arbiter in front of a shared N->M sign-extension stage.
// R requesters offer signed N-bit values over valid/ready. One value is granted
// per free output slot. The winner's value is sign-extended and registered
// together with its index behind a single valid/ready output stage.
module sgnext_rr_arb #(
    parameter  int N   = 12,
    parameter  int M   = 32,
    parameter  int R   = 4,
    localparam int IDW = $clog2(R)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [R-1:0]   i_req_valid,
    input  logic [R*N-1:0] i_req_x,
    output logic [R-1:0]   o_req_ready,
    output logic           o_valid,
    output logic [M-1:0]   o_y,
    output logic [IDW-1:0] o_id,
    input  logic           i_ready
);

    // Sign extension is plain replication of the sign bit; M == N degenerates
    // to a pass-through because the low N bits overwrite the whole word.
    function automatic logic [M-1:0] sext_f(input logic [N-1:0] x);
        logic [M-1:0] r;
        r         = {M{x[N-1]}};
        r[N-1:0]  = x;
        return r;
    endfunction

    logic [N-1:0]   req_x_s [R];
    logic           load_s;
    logic [R-1:0]   grant_s;
    logic           found_s;
    logic [IDW-1:0] gid_s;
    logic [N-1:0]   gx_s;
    logic [IDW:0]   sum_s;
    logic [IDW-1:0] idx_s;

    logic           valid_q, valid_d;
    logic [M-1:0]   y_q, y_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    // Unpack the flat requester bus into one lane per requester.
    for (genvar k = 0; k < R; k++) begin : g_unpack
        assign req_x_s[k] = i_req_x[k*N +: N];
    end

    // The output slot can take a new value when it is empty or being drained.
    always_comb begin
        load_s = ~valid_q | i_ready;
    end

    // Round-robin search starting at ptr; the first valid requester wins.
    // Gated by reset so no requester sees a grant while the block is held in reset.
    always_comb begin
        grant_s = {R{1'b0}};
        found_s = 1'b0;
        gid_s   = {IDW{1'b0}};
        gx_s    = {N{1'b0}};
        sum_s   = {(IDW+1){1'b0}};
        idx_s   = {IDW{1'b0}};
        for (int i = 0; i < R; i++) begin
            sum_s = {1'b0, ptr_q} + (IDW+1)'(i);
            if (sum_s >= (IDW+1)'(R)) begin
                sum_s = sum_s - (IDW+1)'(R);
            end else begin
                sum_s = sum_s;
            end
            idx_s = IDW'(sum_s);
            if (!found_s && load_s && i_rst_n && i_req_valid[idx_s]) begin
                grant_s[idx_s] = 1'b1;
                gid_s          = idx_s;
                gx_s           = req_x_s[idx_s];
                found_s        = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next state of the output stage and priority pointer.
    always_comb begin
        valid_d = valid_q;
        y_d     = y_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        if (load_s) begin
            if (found_s) begin
                valid_d = 1'b1;
                y_d     = sext_f(gx_s);
                id_d    = gid_s;
                ptr_d   = (gid_s == IDW'(R-1)) ? {IDW{1'b0}} : gid_s + IDW'(1);
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Output stage and pointer registers; reset drops any held result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            y_q     <= {M{1'b0}};
            id_q    <= {IDW{1'b0}};
            ptr_q   <= {IDW{1'b0}};
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_req_ready = grant_s;
    assign o_valid     = valid_q;
    assign o_y         = y_q;
    assign o_id        = id_q;

endmodule
